ex_divider: RTL and testbench

- Multi-cycle iterative integer divider in the EX stage of the RV64 pipeline.
- Executes DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW.
- The combinational shifter covers power-of-two scaling; this block covers general division with shift-subtract iteration.
- Valid/ready on both sides: EX issue on the request side, the EX result mux / stall logic on the response side.

---
 rtl/ex_divider.sv | 256 +++++++++++++++++++++++++
 tb/tb_ex_divider.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_divider.sv
// ex_divider: multi-cycle shift-subtract integer divider for the RV64 EX stage.
// Handles DIV/DIVU/REM/REMU and their 32-bit W forms with a restoring
// algorithm. Divide-by-zero and signed overflow are resolved on the accept
// cycle and skip the iteration entirely.
//
// Build option: define EX_DIVIDER_RADIX4_EN to retire two quotient bits per
// CALC cycle instead of one. Results are identical in both builds; only the
// iteration latency changes.

module ex_divider #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_divider_valid_i,
    output logic            ex_divider_ready_o,
    input  logic [2:0]      ex_divider_div_type_i,
    input  logic [XLEN-1:0] ex_divider_dividend_i,
    input  logic [XLEN-1:0] ex_divider_divisor_i,
    input  logic            ex_divider_flush_i,
    output logic            ex_divider_res_valid_o,
    input  logic            ex_divider_res_ready_i,
    output logic [XLEN-1:0] ex_divider_res_data_o
);

    localparam int HALF = XLEN / 2;

    // Iteration counts per CALC phase; the radix-4 build halves them because
    // each cycle retires two quotient bits.
`ifdef EX_DIVIDER_RADIX4_EN
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN / 2);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(HALF / 2);
`else
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(HALF);
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor
    // and keep the difference (setting the new quotient bit) when it fits.
    // The shifted remainder needs one extra bit because an unsigned divisor
    // can be as large as 2^64-1; the kept difference always fits in XLEN.
    function automatic logic [2*XLEN-1:0] div_step(
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] quot,
        input logic [XLEN-1:0] dvs
    );
        logic [XLEN:0]   shifted;
        logic [XLEN-1:0] q_sh;
        logic [XLEN-1:0] r_new;
        shifted = {rem, quot[XLEN-1]};
        q_sh    = {quot[XLEN-2:0], 1'b0};
        if (shifted >= {1'b0, dvs}) begin
            r_new   = shifted[XLEN-1:0] - dvs;
            q_sh[0] = 1'b1;
        end else begin
            r_new = shifted[XLEN-1:0];
        end
        return {r_new, q_sh};
    endfunction

    // Undo the magnitude conversion, pick quotient or remainder, and
    // sign-extend bit 31 for word ops (unsigned word ops included).
    function automatic logic [XLEN-1:0] finalize(
        input logic [XLEN-1:0] quot,
        input logic [XLEN-1:0] rem,
        input logic            neg_quot,
        input logic            neg_rem,
        input logic            rem_sel,
        input logic            word
    );
        logic [XLEN-1:0] q_fix;
        logic [XLEN-1:0] r_fix;
        logic [XLEN-1:0] sel;
        q_fix = neg_quot ? (~quot + 1'b1) : quot;
        r_fix = neg_rem ? (~rem + 1'b1) : rem;
        sel   = rem_sel ? r_fix : q_fix;
        return word ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic              rem_sel_q, rem_sel_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              op_unsigned;
    logic              op_rem_sel;
    logic              op_word;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   min_val;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   pre_quot;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] step1;
    logic [2*XLEN-1:0] step2;

    // Operand preparation for the accept cycle: width extension, magnitudes,
    // special-case detection and the early result for those special cases.
    always_comb begin
        op_unsigned = ex_divider_div_type_i[0];
        op_rem_sel  = ex_divider_div_type_i[1];
        op_word     = ex_divider_div_type_i[2];

        if (op_word) begin
            op_a = op_unsigned ? {{HALF{1'b0}}, ex_divider_dividend_i[HALF-1:0]}
                               : {{HALF{ex_divider_dividend_i[HALF-1]}},
                                  ex_divider_dividend_i[HALF-1:0]};
            op_b = op_unsigned ? {{HALF{1'b0}}, ex_divider_divisor_i[HALF-1:0]}
                               : {{HALF{ex_divider_divisor_i[HALF-1]}},
                                  ex_divider_divisor_i[HALF-1:0]};
            min_val = {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}};
        end else begin
            op_a    = ex_divider_dividend_i;
            op_b    = ex_divider_divisor_i;
            min_val = {1'b1, {(XLEN - 1){1'b0}}};
        end

        sign_a = ~op_unsigned & op_a[XLEN-1];
        sign_b = ~op_unsigned & op_b[XLEN-1];
        mag_a  = sign_a ? (~op_a + 1'b1) : op_a;
        mag_b  = sign_b ? (~op_b + 1'b1) : op_b;

        div_zero = (op_b == '0);
        overflow = ~op_unsigned & (op_a == min_val) & (&op_b);

        // Word ops park the 32-bit magnitude in the upper half so that only
        // 32 shift steps are needed to walk it into the remainder.
        pre_quot = op_word ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;

        if (div_zero) begin
            special_res = finalize('1, op_a, 1'b0, 1'b0, op_rem_sel, op_word);
        end else begin
            special_res = finalize(op_a, '0, 1'b0, 1'b0, op_rem_sel, op_word);
        end
    end

    // Iteration datapath: one or two chained restoring steps per cycle.
    always_comb begin
        step1 = div_step(rem_q, quot_q, dvs_q);
`ifdef EX_DIVIDER_RADIX4_EN
        step2 = div_step(step1[2*XLEN-1:XLEN], step1[XLEN-1:0], dvs_q);
`else
        step2 = step1;
`endif
    end

    // Next-state and register-update logic for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rem_sel_d  = rem_sel_q;
        word_d     = word_q;
        res_d      = res_q;

        case (state_q)
            IDLE: begin
                if (ex_divider_valid_i && !ex_divider_flush_i) begin
                    rem_sel_d = op_rem_sel;
                    word_d    = op_word;
                    if (div_zero || overflow) begin
                        state_d = DONE;
                        res_d   = special_res;
                    end else begin
                        state_d    = CALC;
                        rem_d      = '0;
                        quot_d     = pre_quot;
                        dvs_d      = mag_b;
                        neg_quot_d = sign_a ^ sign_b;
                        neg_rem_d  = sign_a;
                        cnt_d      = op_word ? CNT_WORD : CNT_FULL;
                    end
                end
            end
            CALC: begin
                if (ex_divider_flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = step2[2*XLEN-1:XLEN];
                    quot_d = step2[XLEN-1:0];
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        res_d   = finalize(step2[XLEN-1:0], step2[2*XLEN-1:XLEN],
                                           neg_quot_q, neg_rem_q, rem_sel_q, word_q);
                    end
                end
            end
            DONE: begin
                if (ex_divider_flush_i || ex_divider_res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and datapath registers; reset drops any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            word_q     <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rem_sel_q  <= rem_sel_d;
            word_q     <= word_d;
            res_q      <= res_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        ex_divider_ready_o     = (state_q == IDLE);
        ex_divider_res_valid_o = (state_q == DONE);
        ex_divider_res_data_o  = (state_q == DONE) ? res_q : '0;
    end

endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: randomized and directed stimulus against an arithmetic
// reference model, with a scoreboard queue drained by an independent monitor.

module tb_ex_divider;

`ifdef EX_DIVIDER_RADIX4_EN
    localparam int LAT_FULL = 33;
    localparam int LAT_WORD = 17;
`else
    localparam int LAT_FULL = 65;
    localparam int LAT_WORD = 33;
`endif
    localparam int LAT_SPECIAL = 1;
    localparam int N_DIR = 11;
    localparam int N_RAND = 40;

    localparam logic [2:0] D_TYPE [N_DIR] = '{
        3'b000, 3'b010, 3'b001, 3'b011, 3'b000, 3'b010,
        3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
    localparam logic [63:0] D_A [N_DIR] = '{
        64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
        64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234,
        64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [63:0] D_B [N_DIR] = '{
        64'd2, 64'd2, 64'd0, 64'd0,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
        64'd2, 64'd10, 64'd3};

    typedef struct {
        logic [63:0] data;
        int          t;
        int          lat;
    } exp_t;

    exp_t        scoreboard[$];
    exp_t        cur;
    bit          in_ep = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  div_type = 3'b000;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready;
    logic        dir_ready = 1'b1;
    logic        rand_ready = 1'b1;
    logic        rand_ready_en = 1'b0;
    logic [63:0] res_data;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    assign res_ready = rand_ready_en ? rand_ready : dir_ready;

    always #5 clk = ~clk;

    // Cycle index used to measure accept-to-result latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer backpressure, only used when enabled.
    always @(posedge clk) begin
        #1;
        rand_ready = ($urandom_range(0, 3) != 0);
    end

    ex_divider dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ex_divider_valid_i     (valid),
        .ex_divider_ready_o     (ready),
        .ex_divider_div_type_i  (div_type),
        .ex_divider_dividend_i  (dividend),
        .ex_divider_divisor_i   (divisor),
        .ex_divider_flush_i     (flush),
        .ex_divider_res_valid_o (res_valid),
        .ex_divider_res_ready_i (res_ready),
        .ex_divider_res_data_o  (res_data)
    );

    // RISC-V division semantics computed with native signed/unsigned arithmetic.
    function automatic logic [63:0] refModel(input logic [2:0] t, input logic [63:0] a,
                                             input logic [63:0] b);
        logic            uns;
        logic            rem;
        logic [63:0]     r;
        logic [31:0]     r32;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        longint          sa64, sb64;
        longint unsigned ua64, ub64;
        uns  = t[0];
        rem  = t[1];
        sa32 = a[31:0];
        sb32 = b[31:0];
        ua32 = a[31:0];
        ub32 = b[31:0];
        sa64 = a;
        sb64 = b;
        ua64 = a;
        ub64 = b;
        if (t[2]) begin
            if (b[31:0] == 32'd0)
                r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
            else if (uns)
                r32 = rem ? (ua32 % ub32) : (ua32 / ub32);
            else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                r32 = rem ? 32'd0 : a[31:0];
            else
                r32 = rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0)
                r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (uns)
                r = rem ? (ua64 % ub64) : (ua64 / ub64);
            else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r = rem ? 64'd0 : a;
            else
                r = rem ? 64'(sa64 % sb64) : 64'(sa64 / sb64);
        end
        return r;
    endfunction

    // Divide-by-zero and signed overflow skip the iterations.
    function automatic bit isSpecial(input logic [2:0] t, input logic [63:0] a,
                                     input logic [63:0] b);
        if (t[2])
            return (b[31:0] == 32'd0) ||
                   (!t[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (!t[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: actual 0x%h required 0x%h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Present one request, wait for acceptance and optionally queue its result.
    task automatic applyStimulus(input logic [2:0] t, input logic [63:0] a,
                                 input logic [63:0] b, input bit expect_res,
                                 output int acc_t);
        exp_t e;
        @(posedge clk);
        #1;
        valid    = 1'b1;
        div_type = t;
        dividend = a;
        divisor  = b;
        acc_t    = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready) begin
                acc_t = cyc;
                break;
            end
        end
        if (acc_t < 0) begin
            reportTimeout("accept");
        end else if (expect_res) begin
            e.data = refModel(t, a, b);
            e.t    = acc_t;
            e.lat  = isSpecial(t, a, b) ? LAT_SPECIAL : (t[2] ? LAT_WORD : LAT_FULL);
            scoreboard.push_back(e);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (scoreboard.size() == 0 && ready) return;
        end
        reportTimeout("drain");
    endtask

    // Monitor: the first cycle of each result is matched against the scoreboard
    // head for data and latency; later cycles of the same result must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_ep = 1'b0;
        end else if (res_valid) begin
            checkOutput("ready_in_done", 64'(ready), 64'd0);
            if (!in_ep) begin
                if (scoreboard.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_result: actual 0x%h at cycle %0d", res_data, cyc);
                end else begin
                    cur   = scoreboard.pop_front();
                    in_ep = 1'b1;
                    checkOutput("latency", 64'(cyc - cur.t), 64'(cur.lat));
                    checkOutput("result", res_data, cur.data);
                end
            end else begin
                checkOutput("result_hold", res_data, cur.data);
            end
            if (res_ready || flush) in_ep = 1'b0;
        end else begin
            in_ep = 1'b0;
        end
    end

    // Global time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized traffic with backpressure.
    initial begin
        int t;
        logic [2:0]  rt;
        logic [63:0] ra, rb;

        #3;
        checkOutput("reset_ready", 64'(ready), 64'd1);
        checkOutput("reset_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_data", res_data, 64'd0);
        #19;
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < N_DIR; i++) begin
            applyStimulus(D_TYPE[i], D_A[i], D_B[i], 1'b1, t);
            waitIdle();
        end

        $display("[TB] flush in IDLE");
        @(posedge clk);
        #1;
        valid = 1'b1; flush = 1'b1; div_type = 3'b001; dividend = 64'd100; divisor = 64'd7;
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_blocks", 64'(ready), 64'd1);

        $display("[TB] flush in CALC");
        applyStimulus(3'b001, 64'd100, 64'd7, 1'b0, t);
        while (cyc < t + 10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_ready", 64'(ready), 64'd1);
        checkOutput("flush_valid", 64'(res_valid), 64'd0);
        repeat (70) @(negedge clk);
        applyStimulus(3'b001, 64'd100, 64'd7, 1'b1, t);
        waitIdle();

        $display("[TB] backpressure");
        dir_ready = 1'b0;
        applyStimulus(3'b001, 64'd100, 64'd7, 1'b1, t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) reportTimeout("bp_valid_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 64'(res_valid), 64'd1);
            checkOutput("bp_data", res_data, 64'd14);
            checkOutput("bp_ready", 64'(ready), 64'd0);
        end
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_ready_after", 64'(ready), 64'd1);
        checkOutput("bp_valid_after", 64'(res_valid), 64'd0);

        $display("[TB] reset mid-CALC");
        applyStimulus(3'b000, 64'h0123_4567_89AB_CDEF, 64'd12345, 1'b0, t);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 64'(ready), 64'd1);
        checkOutput("midreset_valid", 64'(res_valid), 64'd0);
        checkOutput("midreset_data", res_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        checkOutput("post_reset_ready", 64'(ready), 64'd1);

        $display("[TB] random traffic");
        rand_ready_en = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            rt = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                end
                1: begin
                    ra = {$urandom(), $urandom()};
                    rb = 64'($urandom_range(1, 1000));
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                2: begin
                    ra = {$urandom(), $urandom()};
                    rb = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom(), 32'd0};
                end
                3: begin
                    ra = rt[2] ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    rb = rt[2] ? {$urandom(), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                4: begin
                    ra = 64'($urandom_range(0, 500));
                    rb = {$urandom(), $urandom()};
                end
                default: begin
                    ra = {$urandom(), $urandom()};
                    rb = {32'd0, $urandom()} >> $urandom_range(0, 31);
                end
            endcase
            applyStimulus(rt, ra, rb, 1'b1, t);
        end
        waitIdle();
        rand_ready_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
